// File: rtl/arb_pkg.sv
// arb_pkg: shared sizes, FSM state and priority-scan helper for the round-robin arbiter
package arb_pkg;
    localparam int N_REQ  = 16;
    localparam int ID_W   = 4;
    localparam int HOLD_W = 5;
    typedef enum logic {IDLE, OWN} state_t;
    function automatic logic [ID_W:0] first_set32(input logic [2*N_REQ-1:0] v);
        logic [ID_W:0] r;
        r = '0;
        for (int i = 2*N_REQ-1; i >= 0; i--) r = v[i] ? {1'b1, ID_W'(i)} : r;
        return r;
    endfunction
endpackage

// File: rtl/onehot2bin_16.sv
// onehot2bin_16: one-hot grant vector to binary index, zero for an all-zero input
module onehot2bin_16
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] oh_i,
    output logic [ID_W-1:0]  bin_o
);
    always_comb begin
        bin_o = '0;
        for (int i = 0; i < N_REQ; i++) bin_o = oh_i[i] ? (bin_o | ID_W'(i)) : bin_o;
    end
endmodule

// File: rtl/rr_arb_16.sv
// rr_arb_16: 16-way round-robin arbiter with registered one-hot grant and optional hold limit
module rr_arb_16
    import arb_pkg::*;
#(
    parameter int HOLD_MAX = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [ID_W-1:0]  gnt_id,
    output logic             gnt_valid,
    output logic             preempt
);
    localparam logic [HOLD_W-1:0] HM = HOLD_W'(HOLD_MAX);
    state_t             state_q, state_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic [ID_W-1:0]    ptr_q, ptr_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic               preempt_q, preempt_d;
    logic               owner_req, timeout, rel, arb;
    logic [N_REQ-1:0]   cand, lo_mask;
    logic [ID_W:0]      win;
    // Upper copy holds the wrapped requests, lower copy only those at or above ptr,
    // so the lowest set bit of the 32-bit word is the round-robin winner.
    always_comb begin
        owner_req = |(req & gnt_q);
        timeout   = state_q == OWN && HM != '0 && hold_q >= HM - 1'b1;
        rel       = state_q == OWN && (!owner_req || timeout);
        arb       = state_q == IDLE || rel;
        cand      = req & ~gnt_q;
        lo_mask   = ~((N_REQ'(1) << ptr_q) - N_REQ'(1));
        win       = first_set32({cand, cand & lo_mask});
        state_d   = arb ? (win[ID_W] ? OWN : IDLE) : state_q;
        gnt_d     = arb ? (win[ID_W] ? N_REQ'(1) << win[ID_W-1:0] : '0) : gnt_q;
        ptr_d     = arb && win[ID_W] ? win[ID_W-1:0] + 1'b1 : ptr_q;
        hold_d    = arb ? '0 : (state_q == OWN && hold_q < HM) ? hold_q + 1'b1 : hold_q;
        preempt_d = rel && timeout && owner_req;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            ptr_q     <= '0;
            hold_q    <= '0;
            preempt_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
            preempt_q <= preempt_d;
        end
    end
    assign gnt       = gnt_q;
    assign gnt_valid = |gnt_q;
    assign preempt   = preempt_q;
    onehot2bin_16 u_o2b (
        .oh_i  (gnt_q),
        .bin_o (gnt_id)
    );
endmodule

// File: tb/tb_rr_arb_16.sv
// tb_rr_arb_16: scoreboard bench for rr_arb_16 with HOLD_MAX=3 and HOLD_MAX=0 instances
module tb_rr_arb_16;
    typedef struct packed {
        logic [15:0] g;
        logic [3:0]  id;
        logic        v;
        logic        p;
    } exp_t;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] req = '0;
    logic [15:0] g0, g1;
    logic [3:0]  id0, id1;
    logic        v0, v1, p0, p1;
    int          checks = 0;
    int          failures = 0;
    int          owner[2];
    int          ptr[2];
    int          held[2];
    int          hm[2] = '{3, 0};
    exp_t        q0[$];
    exp_t        q1[$];
    always #5 clk = ~clk;
    rr_arb_16 #(.HOLD_MAX(3)) dut0 (
        .clk(clk), .rst(rst), .req(req), .gnt(g0), .gnt_id(id0), .gnt_valid(v0), .preempt(p0)
    );
    rr_arb_16 #(.HOLD_MAX(0)) dut1 (
        .clk(clk), .rst(rst), .req(req), .gnt(g1), .gnt_id(id1), .gnt_valid(v1), .preempt(p1)
    );
    function automatic int find(input logic [15:0] r, input int p, input int skip);
        for (int k = 0; k < 16; k++) begin
            int i;
            i = (p + k) % 16;
            if (r[i] && i != skip) return i;
        end
        return -1;
    endfunction
    // Reference: owner index, next-search start, cycles the grant has been visible.
    task automatic step(input int k, input logic [15:0] r, input logic rs);
        int   w;
        logic pre, vol, to;
        exp_t e;
        pre = 1'b0;
        if (rs) begin
            owner[k] = -1;
            ptr[k]   = 0;
            held[k]  = 0;
        end else if (owner[k] < 0) begin
            w = find(r, ptr[k], -1);
            if (w >= 0) begin
                owner[k] = w;
                ptr[k]   = (w + 1) % 16;
                held[k]  = 0;
            end
        end else begin
            held[k]++;
            vol = !r[owner[k]];
            to  = hm[k] != 0 && held[k] >= hm[k];
            if (vol || to) begin
                pre = to && !vol;
                w = find(r, ptr[k], owner[k]);
                if (w >= 0) begin
                    owner[k] = w;
                    ptr[k]   = (w + 1) % 16;
                    held[k]  = 0;
                end else owner[k] = -1;
            end
        end
        e.g  = owner[k] >= 0 ? 16'(1) << owner[k] : 16'h0;
        e.id = owner[k] >= 0 ? 4'(owner[k]) : 4'h0;
        e.v  = owner[k] >= 0;
        e.p  = pre;
        if (k == 0) q0.push_back(e);
        else q1.push_back(e);
    endtask
    task automatic cmp(input string what, input int k, input exp_t e, input exp_t a);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s inst%0d @%0t: got gnt=%h id=%0d valid=%b preempt=%b, want gnt=%h id=%0d valid=%b preempt=%b",
                     what, k, $time, a.g, a.id, a.v, a.p, e.g, e.id, e.v, e.p);
        end
    endtask
    task automatic rst_chk();
        cmp("async_reset", 0, '0, {g0, id0, v0, p0});
        cmp("async_reset", 1, '0, {g1, id1, v1, p1});
    endtask
    task automatic cycle(input logic [15:0] r, input logic rs);
        @(negedge clk);
        req = r;
        rst = rs;
        step(0, r, rs);
        step(1, r, rs);
        if (rs) begin
            #1;
            rst_chk();
        end
    endtask
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (q0.size() > 0) cmp("grant", 0, q0.pop_front(), {g0, id0, v0, p0});
            if (q1.size() > 0) cmp("grant", 1, q1.pop_front(), {g1, id1, v1, p1});
        end
    end
    initial begin
        logic [15:0] r;
        rst = 1'b1;
        #1;
        rst_chk();
        cycle(16'h0000, 1'b1);
        cycle(16'h0001, 1'b0);
        repeat (2) cycle(16'h0000, 1'b0);
        cycle(16'h0000, 1'b1);
        cycle(16'hFFFF, 1'b0);
        repeat (17) begin
            cycle(16'hFFFF & ~(16'(1) << owner[1]), 1'b0);
            cycle(16'hFFFF, 1'b0);
        end
        cycle(16'h0000, 1'b1);
        cycle(16'h0001, 1'b0);
        cycle(16'h0000, 1'b0);
        repeat (2) cycle(16'h8001, 1'b0);
        repeat (2) cycle(16'h0001, 1'b0);
        cycle(16'h0000, 1'b1);
        repeat (10) cycle(16'h0010, 1'b0);
        cycle(16'h0000, 1'b1);
        repeat (12) cycle(16'h0030, 1'b0);
        cycle(16'h0000, 1'b1);
        repeat (3) cycle(16'h0080, 1'b0);
        cycle(16'h0080, 1'b1);
        repeat (2) cycle(16'h0080, 1'b0);
        r = '0;
        repeat (3000) begin
            case ($urandom_range(0, 9))
                0:       r = 16'($urandom);
                7:       r = r & 16'($urandom);
                8:       r = ($urandom_range(0, 3) == 0) ? 16'h0 : r;
                default: r = r ^ (16'(1) << $urandom_range(0, 15));
            endcase
            cycle(r, $urandom_range(0, 149) == 0);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d/%0d pending, want 0/0", q0.size(), q1.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
